// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - ALU/branch reservation station: CDB snoop, insert bypass, one issue per cycle
// Define RS_OLDEST_FIRST_EN for age-ordered select; otherwise the lowest-index ready entry issues.
module alu_rs #(
   parameter int RS_SIZE = 8,
   parameter int OP_W    = 5,
   parameter int ROB_W   = 4
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   input  logic             clr_in,
   input  logic             dispatch_valid,
   input  logic [OP_W-1:0]  dispatch_op,
   input  logic [31:0]      dispatch_rs1_val,
   input  logic [31:0]      dispatch_rs2_val,
   input  logic             dispatch_rs1_rdy,
   input  logic             dispatch_rs2_rdy,
   input  logic [ROB_W-1:0] dispatch_rs1_tag,
   input  logic [ROB_W-1:0] dispatch_rs2_tag,
   input  logic [31:0]      dispatch_imm,
   input  logic [31:0]      dispatch_pc,
   input  logic [ROB_W-1:0] dispatch_rob_index,
   input  logic             alu_ready,
   input  logic [31:0]      alu_result,
   input  logic [ROB_W-1:0] alu_rob_index,
   input  logic             lsb_ready,
   input  logic [31:0]      lsb_result,
   input  logic [ROB_W-1:0] lsb_rob_index,
   output logic             rs_full,
   output logic             rs_to_alu_ready,
   output logic [OP_W-1:0]  rs_to_alu_op,
   output logic [31:0]      rs_to_alu_rs1,
   output logic [31:0]      rs_to_alu_rs2,
   output logic [ROB_W-1:0] rs_to_alu_rob_index,
   output logic [31:0]      rs_to_alu_PC,
   output logic [31:0]      rs_to_alu_imm
);
   localparam int IDX_W = $clog2(RS_SIZE);

   logic [RS_SIZE-1:0] r_busy;
   logic [RS_SIZE-1:0] r_qj_rdy;
   logic [RS_SIZE-1:0] r_qk_rdy;
   logic [OP_W-1:0]    r_op  [RS_SIZE];
   logic [31:0]        r_vj  [RS_SIZE];
   logic [31:0]        r_vk  [RS_SIZE];
   logic [31:0]        r_imm [RS_SIZE];
   logic [31:0]        r_pc  [RS_SIZE];
   logic [ROB_W-1:0]   r_qj  [RS_SIZE];
   logic [ROB_W-1:0]   r_qk  [RS_SIZE];
   logic [ROB_W-1:0]   r_rob [RS_SIZE];

   logic [RS_SIZE-1:0] w_cand;
   logic [IDX_W-1:0]   w_free_idx;
   logic               w_sel_found;
   logic [IDX_W-1:0]   w_sel_idx;
   logic               w_ins;
   logic [31:0]        w_ins_vj;
   logic [31:0]        w_ins_vk;
   logic               w_ins_jr;
   logic               w_ins_kr;

   assign rs_full = &r_busy;
   assign w_ins   = dispatch_valid && !rs_full;
   // Candidates come from registered state only, so a same-cycle wakeup waits one cycle.
   assign w_cand  = r_busy & r_qj_rdy & r_qk_rdy;

   always_comb begin
      w_free_idx = '0;
      for (int i = RS_SIZE-1; i >= 0; i--) begin
         if (!r_busy[i]) w_free_idx = IDX_W'(i);
      end
   end

   always_comb begin
      w_ins_vj = dispatch_rs1_val;
      w_ins_jr = dispatch_rs1_rdy;
      if (!dispatch_rs1_rdy && alu_ready && dispatch_rs1_tag == alu_rob_index) begin
         w_ins_vj = alu_result;
         w_ins_jr = 1'b1;
      end else if (!dispatch_rs1_rdy && lsb_ready && dispatch_rs1_tag == lsb_rob_index) begin
         w_ins_vj = lsb_result;
         w_ins_jr = 1'b1;
      end
      w_ins_vk = dispatch_rs2_val;
      w_ins_kr = dispatch_rs2_rdy;
      if (!dispatch_rs2_rdy && alu_ready && dispatch_rs2_tag == alu_rob_index) begin
         w_ins_vk = alu_result;
         w_ins_kr = 1'b1;
      end else if (!dispatch_rs2_rdy && lsb_ready && dispatch_rs2_tag == lsb_rob_index) begin
         w_ins_vk = lsb_result;
         w_ins_kr = 1'b1;
      end
   end

`ifdef RS_OLDEST_FIRST_EN
   // Row i bit j set: entry j was inserted before entry i.
   logic [RS_SIZE-1:0] r_age [RS_SIZE];
   logic [RS_SIZE-1:0] w_sel_mask;

   assign w_sel_mask = w_sel_found ? (RS_SIZE'(1) << w_sel_idx) : '0;

   always_comb begin
      w_sel_found = 1'b0;
      w_sel_idx   = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         if (w_cand[i] && ((r_age[i] & w_cand) == '0)) begin
            w_sel_found = 1'b1;
            w_sel_idx   = IDX_W'(i);
         end
      end
   end
`else
   always_comb begin
      w_sel_found = 1'b0;
      w_sel_idx   = '0;
      for (int i = RS_SIZE-1; i >= 0; i--) begin
         if (w_cand[i]) begin
            w_sel_found = 1'b1;
            w_sel_idx   = IDX_W'(i);
         end
      end
   end
`endif

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_busy   <= '0;
         r_qj_rdy <= '0;
         r_qk_rdy <= '0;
         for (int i = 0; i < RS_SIZE; i++) begin
            r_op[i]  <= '0;
            r_vj[i]  <= '0;
            r_vk[i]  <= '0;
            r_imm[i] <= '0;
            r_pc[i]  <= '0;
            r_qj[i]  <= '0;
            r_qk[i]  <= '0;
            r_rob[i] <= '0;
`ifdef RS_OLDEST_FIRST_EN
            r_age[i] <= '0;
`endif
         end
         rs_to_alu_ready     <= 1'b0;
         rs_to_alu_op        <= '0;
         rs_to_alu_rs1       <= '0;
         rs_to_alu_rs2       <= '0;
         rs_to_alu_rob_index <= '0;
         rs_to_alu_PC        <= '0;
         rs_to_alu_imm       <= '0;
      end else if (clr_in) begin
         r_busy          <= '0;
         rs_to_alu_ready <= 1'b0;
`ifdef RS_OLDEST_FIRST_EN
         for (int i = 0; i < RS_SIZE; i++) r_age[i] <= '0;
`endif
      end else if (rdy_in) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (r_busy[i] && !r_qj_rdy[i]) begin
               if (alu_ready && r_qj[i] == alu_rob_index) begin
                  r_vj[i]     <= alu_result;
                  r_qj_rdy[i] <= 1'b1;
               end else if (lsb_ready && r_qj[i] == lsb_rob_index) begin
                  r_vj[i]     <= lsb_result;
                  r_qj_rdy[i] <= 1'b1;
               end
            end
            if (r_busy[i] && !r_qk_rdy[i]) begin
               if (alu_ready && r_qk[i] == alu_rob_index) begin
                  r_vk[i]     <= alu_result;
                  r_qk_rdy[i] <= 1'b1;
               end else if (lsb_ready && r_qk[i] == lsb_rob_index) begin
                  r_vk[i]     <= lsb_result;
                  r_qk_rdy[i] <= 1'b1;
               end
            end
         end
         rs_to_alu_ready <= w_sel_found;
         if (w_sel_found) begin
            rs_to_alu_op        <= r_op[w_sel_idx];
            rs_to_alu_rs1       <= r_vj[w_sel_idx];
            rs_to_alu_rs2       <= r_vk[w_sel_idx];
            rs_to_alu_rob_index <= r_rob[w_sel_idx];
            rs_to_alu_PC        <= r_pc[w_sel_idx];
            rs_to_alu_imm       <= r_imm[w_sel_idx];
            r_busy[w_sel_idx]   <= 1'b0;
         end
         // The insert slot is never busy, so it cannot collide with the issuing entry.
         if (w_ins) begin
            r_busy[w_free_idx]   <= 1'b1;
            r_op[w_free_idx]     <= dispatch_op;
            r_vj[w_free_idx]     <= w_ins_vj;
            r_vk[w_free_idx]     <= w_ins_vk;
            r_qj_rdy[w_free_idx] <= w_ins_jr;
            r_qk_rdy[w_free_idx] <= w_ins_kr;
            r_qj[w_free_idx]     <= dispatch_rs1_tag;
            r_qk[w_free_idx]     <= dispatch_rs2_tag;
            r_imm[w_free_idx]    <= dispatch_imm;
            r_pc[w_free_idx]     <= dispatch_pc;
            r_rob[w_free_idx]    <= dispatch_rob_index;
         end
`ifdef RS_OLDEST_FIRST_EN
         for (int i = 0; i < RS_SIZE; i++) begin
            if (w_sel_found) r_age[i][w_sel_idx] <= 1'b0;
         end
         if (w_ins) r_age[w_free_idx] <= r_busy & ~w_sel_mask;
`endif
      end
   end
endmodule
